branch_update_scheduler: RTL
============================

Name: branch_update_scheduler

Overview:
Collects resolved-branch updates from two execute-side requesters and serialises them onto the single update interface of the branch hardware (predictor + BTB). Requester 0 is the conditional-branch unit; requester 1 is the jump unit (JAL/JALR). Concurrent requests are arbitrated round-robin into a small FIFO. The FIFO drains at most one update per cycle, and a hold input can freeze the drain.

Parameters:
DATA_WIDTH, 32, width of PC and target fields
FIFO_DEPTH, 4, update queue entries (power of two, >=2)
CNT_WIDTH, 3, occupancy counter width (log2(FIFO_DEPTH)+1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
br_valid  input  1  conditional-branch update request
br_ready  output  1  conditional-branch request accepted this cycle
br_taken  input  1  resolved direction
br_pc  input  DATA_WIDTH  branch PC
br_target  input  DATA_WIDTH  resolved target
jmp_valid  input  1  jump update request
jmp_ready  output  1  jump request accepted this cycle
jmp_pc  input  DATA_WIDTH  jump PC
jmp_target  input  DATA_WIDTH  resolved jump target
hold  input  1  freeze draining (queue still accepts)
update_predictor  output  1  predictor update strobe
update_btb  output  1  BTB update strobe
actually_taken  output  1  resolved direction to predictor
resolved_pc  output  DATA_WIDTH  PC of update
resolved_pc_target  output  DATA_WIDTH  target of update
pending  output  CNT_WIDTH  current FIFO occupancy

Behaviour:
- Reset (async, rst=1): FIFO empty, pending=0, rr pointer favours requester 0, all update_* / actually_taken / resolved_* = 0. Reset mid-operation discards queued entries; no strobe in the cycle after release.
- Handshake: a request is accepted at a rising edge when valid && ready. Payload is captured on that edge.
- Space: space = (pending < FIFO_DEPTH), using the registered count. The same-cycle pop does not free a slot, so there is no combinational path from hold to ready.
- Arbitration, one accept per cycle:
  - Only one requester valid and space=1: that requester's ready=1.
  - Both valid and space=1: ready goes to the rr-favoured requester; the other's ready=0.
  - The rr pointer flips to the other requester only when a grant occurs while both were valid.
  - ready is 0 whenever the corresponding valid is 0.
- Entry encoding:
  - Branch: pred_upd=1, btb_upd=br_taken, taken=br_taken, pc=br_pc, target=br_target.
  - Jump: pred_upd=0, btb_upd=1, taken=1, pc=jmp_pc, target=jmp_target.
- Drain: at an edge with pending>0 (pre-edge value) and hold=0, the head entry pops into the registered outputs.
  - update_predictor / update_btb are high for exactly one cycle per popped entry.
  - Otherwise both strobes are 0. actually_taken and resolved_* hold their last values.
- Latency: accept at edge E, strobe visible in cycle after edge E+1 (2-edge minimum). Throughput: 1 update/cycle sustained.
- Simultaneous push and pop: both happen at the same edge. pending is unchanged and FIFO order is preserved.
- Full with pop: ready stays 0 that cycle (conservative). A slot is accepted the following cycle.
- hold: while hold=1, no pops occur and strobes are 0, but accepts continue until full. On release, draining resumes the next edge.
- Pointers: wrap modulo FIFO_DEPTH. pending ranges 0..FIFO_DEPTH and never overflows or underflows.
- Ordering: updates exit in strict acceptance order.

Test Plan:
- Single branch: br_valid=1, taken=1, pc=0x100, target=0x200 for one cycle -> br_ready=1. Two edges later, update_predictor=1, update_btb=1, actually_taken=1, resolved_pc=0x100, resolved_pc_target=0x200 for exactly 1 cycle.
- Not-taken branch then jump: branch at pc=0x104 (taken=0), then jump pc=0x108 target=0x40.
  - Branch strobe: pred=1, btb=0, taken=0.
  - Next-cycle jump strobe: pred=0, btb=1, taken=1, target=0x40.
- Contention: both valid continuously for 4 cycles -> grants alternate br, jmp, br, jmp (first to br after reset). Outputs emerge in the same order.
- Full/hold: hold=1, 5 jump requests -> first 4 accepted, pending=4, jmp_ready=0 on the 5th.
  - Release hold: 4 consecutive strobes in order.
  - 5th request is accepted the cycle after the first pop.
- Push+pop: steady single-requester stream with hold=0 -> pending stays at 1, one strobe per cycle, no gaps.
- Reset mid-queue: pending=3, assert rst asynchronously -> all outputs 0 immediately, pending=0. No strobes after release until new requests.

Source files
------------

// File: rtl/branch_update_scheduler.sv
// Round-robin arbiter feeding a small FIFO that serialises resolved branch/jump
// updates onto the single predictor/BTB update port, one pop per cycle.
module branch_update_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_pc,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic                  jmp_valid,
    output logic                  jmp_ready,
    input  logic [DATA_WIDTH-1:0] jmp_pc,
    input  logic [DATA_WIDTH-1:0] jmp_target,
    input  logic                  hold,
    output logic                  update_predictor,
    output logic                  update_btb,
    output logic                  actually_taken,
    output logic [DATA_WIDTH-1:0] resolved_pc,
    output logic [DATA_WIDTH-1:0] resolved_pc_target,
    output logic [CNT_WIDTH-1:0]  pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic                  pred_upd;
        logic                  btb_upd;
        logic                  taken;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] target;
    } entry_t;

    entry_t               r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_rr;      // 0: branch unit favoured, 1: jump unit favoured

    logic   w_space;
    logic   w_push;
    logic   w_pop;
    entry_t w_entry;
    entry_t w_head;

    // Space uses the registered count only, so ready never depends on hold.
    assign w_space   = (r_count < CNT_WIDTH'(FIFO_DEPTH));
    assign br_ready  = w_space & br_valid  & (~jmp_valid | ~r_rr);
    assign jmp_ready = w_space & jmp_valid & (~br_valid  |  r_rr);
    assign w_push    = br_ready | jmp_ready;
    assign w_pop     = (r_count != '0) & ~hold;
    assign w_head    = r_mem[r_rd_ptr];
    assign pending   = r_count;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_entry = '0;
        if (br_ready) begin
            w_entry.pred_upd = 1'b1;
            w_entry.btb_upd  = br_taken;
            w_entry.taken    = br_taken;
            w_entry.pc       = br_pc;
            w_entry.target   = br_target;
        end else if (jmp_ready) begin
            w_entry.pred_upd = 1'b0;
            w_entry.btb_upd  = 1'b1;
            w_entry.taken    = 1'b1;
            w_entry.pc       = jmp_pc;
            w_entry.target   = jmp_target;
        end
    end

    // NOTE: queue storage is not reset; clearing the pointers and count is what empties the queue.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
            if (br_valid && jmp_valid && w_push) begin
                r_rr <= ~r_rr;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_predictor   <= 1'b0;
            update_btb         <= 1'b0;
            actually_taken     <= 1'b0;
            resolved_pc        <= '0;
            resolved_pc_target <= '0;
        end else begin
            update_predictor <= w_pop & w_head.pred_upd;
            update_btb       <= w_pop & w_head.btb_upd;
            if (w_pop) begin
                actually_taken     <= w_head.taken;
                resolved_pc        <= w_head.pc;
                resolved_pc_target <= w_head.target;
            end
        end
    end

endmodule
